alu_issue_stage: RTL and testbench

In-order issue stage feeding the ALU stage through `alu_issue_if`. Buffers decoded uops in a small FIFO and tracks pending destination registers in a scoreboard. Reads operands from the register file, with a writeback bypass, and issues at most one hazard-free uop per cycle into a registered output. Honours the same `i_stall`/`i_flush` controls as the ALU stage.

---
 rtl/riscv_uop_pkg.sv | 34 +++
 rtl/alu_issue_if.sv | 12 +
 rtl/issue_scoreboard.sv | 37 +++
 rtl/alu_issue_stage.sv | 142 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_uop_pkg.sv
// Decoded-uop types shared by the issue stage, its scoreboard and the ALU-side interface.
package riscv_uop_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    reg_idx_t        rs1;
    reg_idx_t        rs2;
    reg_idx_t        rd;
    logic            rd_we;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic            use_pc;
    logic [XLEN-1:0] pc;
    alu_op_t         alu_op;
  } uop_t;

endpackage

// File: rtl/alu_issue_if.sv
// Registered issue bus from the issue stage into the ALU stage.
interface alu_issue_if;
  import riscv_uop_pkg::*;

  logic            m_valid;
  uop_t            m_uop;
  logic [XLEN-1:0] m_op1;
  logic [XLEN-1:0] m_op2;

  modport issue (output m_valid, m_uop, m_op1, m_op2);
  modport alu   (input  m_valid, m_uop, m_op1, m_op2);
endinterface

// File: rtl/issue_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register, x0 never busy.
module issue_scoreboard
  import riscv_uop_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             set_valid,
  input  reg_idx_t         set_rd,
  input  logic             clr_valid,
  input  reg_idx_t         clr_rd,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;

  // Clear is applied first so an issue and a writeback to the same rd leave it busy.
  always_comb begin
    // NOTE: sb_d takes a full default before the conditional updates, so no latch can form.
    sb_d = sb_q;
    if (clr_valid) sb_d[clr_rd] = 1'b0;
    if (set_valid && (set_rd != '0)) sb_d[set_rd] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sb_q <= '0;
    else if (flush) sb_q <= '0;
    else            sb_q <= sb_d;
  end

  assign busy = sb_q;

endmodule

// File: rtl/alu_issue_stage.sv
// In-order issue stage: uop FIFO, scoreboard hazard check, operand read with writeback
// bypass, and a registered single-uop issue slot toward the ALU.
module alu_issue_stage
  import riscv_uop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_dec_valid,
  input  uop_t            i_dec_uop,
  output logic            o_dec_ready,
  output reg_idx_t        o_rf_raddr1,
  output reg_idx_t        o_rf_raddr2,
  input  logic [XLEN-1:0] i_rf_rdata1,
  input  logic [XLEN-1:0] i_rf_rdata2,
  input  logic            i_wb_valid,
  input  reg_idx_t        i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_stall,
  input  logic            i_flush,
  alu_issue_if.issue      issue_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  uop_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  uop_t             head;
  logic             head_valid;
  logic             push;
  logic             pop;
  logic             head_ok;
  logic [NREGS-1:0] busy;
  logic             wb_hit1;
  logic             wb_hit2;
  logic             wb_hit_rd;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;

  // Ready depends only on the count: a full queue never accepts, even while popping.
  assign o_dec_ready = (count != CNT_W'(DEPTH));
  assign head_valid  = (count != '0);
  assign head        = mem[rd_ptr];
  assign o_rf_raddr1 = head_valid ? head.rs1 : '0;
  assign o_rf_raddr2 = head_valid ? head.rs2 : '0;

  assign push = i_dec_valid && o_dec_ready && !i_flush;
  assign pop  = head_ok && !i_stall;

  always_comb begin
    wb_hit1   = i_wb_valid && (i_wb_rd == head.rs1);
    wb_hit2   = i_wb_valid && (i_wb_rd == head.rs2);
    wb_hit_rd = i_wb_valid && (i_wb_rd == head.rd);

    // A writeback landing this cycle resolves the hazard it would otherwise cause.
    raw1 = !head.use_pc  && (head.rs1 != '0) && busy[head.rs1] && !wb_hit1;
    raw2 = !head.use_imm && (head.rs2 != '0) && busy[head.rs2] && !wb_hit2;
    waw  = head.rd_we    && (head.rd  != '0) && busy[head.rd]  && !wb_hit_rd;

    head_ok = head_valid && !raw1 && !raw2 && !waw;

    if (head.rs1 == '0) rs1_val = '0;
    else if (wb_hit1)   rs1_val = i_wb_data;
    else                rs1_val = i_rf_rdata1;

    if (head.rs2 == '0) rs2_val = '0;
    else if (wb_hit2)   rs2_val = i_wb_data;
    else                rs2_val = i_rf_rdata2;

    op1 = head.use_pc  ? head.pc  : rs1_val;
    op2 = head.use_imm ? head.imm : rs2_val;
  end

  // NOTE: the queue storage has no reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_dec_uop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue slot: a bubble only drops m_valid, the payload holds its last issued value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_if.m_valid <= 1'b0;
      issue_if.m_uop   <= '0;
      issue_if.m_op1   <= '0;
      issue_if.m_op2   <= '0;
    end else if (i_flush) begin
      issue_if.m_valid <= 1'b0;
    end else if (!i_stall) begin
      issue_if.m_valid <= head_ok;
      if (head_ok) begin
        issue_if.m_uop <= head;
        issue_if.m_op1 <= op1;
        issue_if.m_op2 <= op2;
      end
    end
  end

  issue_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_flush),
    .set_valid (pop && head.rd_we),
    .set_rd    (head.rd),
    .clr_valid (i_wb_valid),
    .clr_rd    (i_wb_rd),
    .busy      (busy)
  );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized bench for alu_issue_stage against a queue-based reference model.
module tb_alu_issue_stage;
  import riscv_uop_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_valid;
  uop_t        dec_uop;
  logic        dec_ready;
  reg_idx_t    raddr1;
  reg_idx_t    raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        wb_valid;
  reg_idx_t    wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        flush;

  logic [31:0] rf [32];
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  alu_issue_if aif ();

  alu_issue_stage #(.DEPTH(DEPTH), .NREGS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_dec_valid (dec_valid),
    .i_dec_uop   (dec_uop),
    .o_dec_ready (dec_ready),
    .o_rf_raddr1 (raddr1),
    .o_rf_raddr2 (raddr2),
    .i_rf_rdata1 (rdata1),
    .i_rf_rdata2 (rdata2),
    .i_wb_valid  (wb_valid),
    .i_wb_rd     (wb_rd),
    .i_wb_data   (wb_data),
    .i_stall     (stall),
    .i_flush     (flush),
    .issue_if    (aif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  uop_t        q[$];
  logic [31:0] msb;
  logic        exp_valid;
  uop_t        exp_uop;
  logic [31:0] exp_op1;
  logic [31:0] exp_op2;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic uop_t mk(input int rs1, input int rs2, input int rd, input logic we,
                              input logic ui, input logic [31:0] imm, input logic up,
                              input logic [31:0] pc);
    uop_t u;
    u.rs1 = reg_idx_t'(rs1); u.rs2 = reg_idx_t'(rs2); u.rd = reg_idx_t'(rd);
    u.rd_we = we; u.use_imm = ui; u.imm = imm; u.use_pc = up; u.pc = pc;
    u.alu_op = alu_op_t'($urandom_range(0, 9));
    return u;
  endfunction

  function automatic uop_t rand_uop();
    return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3) == 0, $urandom);
  endfunction

  // A register blocks the head when it is used, nonzero, pending, and not written back now.
  function automatic logic reg_free(input reg_idx_t r, input logic used);
    return !(used && r != 0 && msb[r] && !(wb_valid && wb_rd == r));
  endfunction

  function automatic logic [31:0] reg_val(input reg_idx_t r);
    if (r == 0) return 32'h0;
    if (wb_valid && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  task automatic model_reset();
    q.delete();
    msb = '0;
    exp_valid = 1'b0;
    exp_uop = '0;
    exp_op1 = '0;
    exp_op2 = '0;
  endtask

  task automatic step();
    uop_t h;
    logic hv, rdy, ok;
    logic [31:0] v1, v2;
    hv  = q.size() != 0;
    rdy = q.size() < DEPTH;
    h   = '0;
    if (hv) h = q[0];
    check("dec_ready", 96'(dec_ready), 96'(rdy));
    check("rf_raddr1", 96'(raddr1), 96'(h.rs1));
    check("rf_raddr2", 96'(raddr2), 96'(h.rs2));
    ok = hv && reg_free(h.rs1, !h.use_pc) && reg_free(h.rs2, !h.use_imm) && reg_free(h.rd, h.rd_we);
    v1 = h.use_pc  ? h.pc  : reg_val(h.rs1);
    v2 = h.use_imm ? h.imm : reg_val(h.rs2);
    if (flush) begin
      q.delete();
      msb = '0;
      exp_valid = 1'b0;
    end else begin
      if (!stall) begin
        exp_valid = ok;
        if (ok) begin exp_uop = h; exp_op1 = v1; exp_op2 = v2; end
      end
      if (wb_valid) msb[wb_rd] = 1'b0;
      if (ok && !stall) begin
        if (h.rd_we && h.rd != 0) msb[h.rd] = 1'b1;
        void'(q.pop_front());
      end
      if (dec_valid && rdy) q.push_back(dec_uop);
    end
    @(posedge clk);
    #1;
    check("m_valid", 96'(aif.m_valid), 96'(exp_valid));
    check("m_uop", 96'(aif.m_uop), 96'(exp_uop));
    check("m_op1", 96'(aif.m_op1), 96'(exp_op1));
    check("m_op2", 96'(aif.m_op2), 96'(exp_op2));
    check("scoreboard", 96'(dut.busy), 96'(msb));
    @(negedge clk);
  endtask

  task automatic cyc(input logic dv, input uop_t u, input logic wv, input reg_idx_t wr,
                     input logic [31:0] wd, input logic st, input logic fl);
    dec_valid = dv; dec_uop = u; wb_valid = wv; wb_rd = wr; wb_data = wd;
    stall = st; flush = fl;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic clear_sb();
    for (int r = 1; r < 32; r++)
      if (msb[r]) cyc(1'b0, '0, 1'b1, reg_idx_t'(r), $urandom, 1'b0, 1'b0);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_m_valid"}, 96'(aif.m_valid), 96'(0));
    check({tag, "_m_uop"},   96'(aif.m_uop),   96'(0));
    check({tag, "_m_op1"},   96'(aif.m_op1),   96'(0));
    check({tag, "_m_op2"},   96'(aif.m_op2),   96'(0));
    check({tag, "_ready"},   96'(dec_ready),   96'(1));
    check({tag, "_raddr1"},  96'(raddr1),      96'(0));
    check({tag, "_sb"},      96'(dut.busy),    96'(0));
    model_reset();
    dec_valid = 1'b0; wb_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    uop_t ua, ub;
    dec_valid = 1'b0; dec_uop = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hA5A5_0001;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    reset_check("reset");

    // Independent stream: addi x1..x4, imm 1..4
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, mk(0, 0, i, 1'b1, 1'b1, 32'(i), 1'b0, 0), 1'b0, '0, '0, 1'b0, 1'b0);
    check("stream_last_op2", 96'(aif.m_op2), 96'(3));
    idle(2);
    check("stream_final_op2", 96'(aif.m_op2), 96'(4));
    clear_sb();

    // RAW with writeback bypass
    cyc(1'b1, mk(1, 2, 5, 1'b1, 1'b0, 0, 1'b0, 0), 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, mk(5, 3, 6, 1'b1, 1'b0, 0, 1'b0, 0), 1'b0, '0, '0, 1'b0, 1'b0);
    idle(2);
    check("raw_bubble", 96'(aif.m_valid), 96'(0));
    cyc(1'b0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("raw_issue", 96'(aif.m_valid), 96'(1));
    check("raw_bypass_op1", 96'(aif.m_op1), 96'(32'hDEAD_BEEF));
    check("raw_sb5_clear", 96'(dut.busy[5]), 96'(0));
    clear_sb();

    // Full queue under stall, then release
    for (int i = 0; i < 4; i++)
      cyc(1'b1, mk(0, 0, 10 + i, 1'b1, 1'b1, 32'h100 + 32'(i), 1'b0, 0), 1'b0, '0, '0, 1'b1, 1'b0);
    check("full_ready_low", 96'(dec_ready), 96'(0));
    ua = mk(0, 0, 14, 1'b1, 1'b1, 32'h104, 1'b0, 0);
    cyc(1'b1, ua, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, ua, 1'b0, '0, '0, 1'b0, 1'b0);
    check("full_ready_back", 96'(dec_ready), 96'(1));
    cyc(1'b1, ua, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(5);
    check("full_order_last", 96'(aif.m_op2), 96'(32'h104));
    clear_sb();

    // Stall hold with a writeback during the stall
    ua = mk(0, 0, 12, 1'b1, 1'b1, 32'h55, 1'b0, 0);
    ub = mk(0, 0, 13, 1'b1, 1'b1, 32'h66, 1'b0, 0);
    cyc(1'b1, ua, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, ub, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, i == 0, 5'd12, 32'h1234, 1'b1, 1'b0);
      check("stall_hold_valid", 96'(aif.m_valid), 96'(1));
      check("stall_hold_uop", 96'(aif.m_uop), 96'(ua));
    end
    check("stall_sb12_clear", 96'(dut.busy[12]), 96'(0));
    idle(2);
    clear_sb();

    // Flush with a concurrent decode offer
    cyc(1'b1, mk(0, 0, 7, 1'b1, 1'b1, 32'h7, 1'b0, 0), 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, mk(0, 0, 0, 1'b0, 1'b1, 32'h200 + 32'(i), 1'b0, 0), 1'b0, '0, '0, 1'b1, 1'b0);
    check("flush_pre_sb7", 96'(dut.busy[7]), 96'(1));
    cyc(1'b1, mk(0, 0, 9, 1'b1, 1'b1, 32'h999, 1'b0, 0), 1'b0, '0, '0, 1'b1, 1'b1);
    check("flush_count", 96'(dut.count), 96'(0));
    check("flush_valid", 96'(aif.m_valid), 96'(0));
    check("flush_sb", 96'(dut.busy), 96'(0));
    idle(2);

    // x0 source and destination
    cyc(1'b1, mk(0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 0), 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1);
    check("x0_valid", 96'(aif.m_valid), 96'(1));
    check("x0_op1", 96'(aif.m_op1), 96'(0));
    check("x0_sb", 96'(dut.busy), 96'(0));

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c == 200) reset_check("mid_reset");
      cyc($urandom_range(0, 99) < 70, rand_uop(), $urandom_range(0, 99) < 40,
          reg_idx_t'($urandom_range(0, 7)), $urandom, $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 3);
    end
    for (int k = 0; k < 3; k++) begin
      clear_sb();
      idle(DEPTH + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
